int_service_seq: RTL and testbench

- CPU-side responder for the interrupt controller. Consumes its priority code/break request and runs the entry sequence: save return PC, acknowledge (clear) the serviced request line, raise the mask, redirect fetch to the level vector.
- Handles ERET: pops the saved context, restores the mask and redirects fetch back.
- Drives the controller's clear (IG), mask (INM) and enable (IE) inputs, closing the loop.

---
 rtl/int_service_seq.sv | 142 ++++++++++++++
 tb/tb_int_service_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/int_service_seq.sv
// Interrupt service sequencer: runs the entry (save/ack/mask/vector) and ERET return sequences.
// Optional INT_NEST_EN: re-enable interrupts on entry so higher levels can preempt, up to DEPTH.
module int_service_seq #(
   parameter int              PC_W       = 32,
   parameter int              DEPTH      = 3,
   parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(32'h0000_0100),
   parameter logic [PC_W-1:0] VEC_STRIDE = PC_W'(32'h10)
) (
   input  logic            in_CLK,
   input  logic            in_RST,
   input  logic [1:0]      in_code,
   input  logic            in_break,
   input  logic [PC_W-1:0] in_PC,
   input  logic            in_ERET,
   input  logic            in_EI,
   input  logic            in_DI,
   output logic            out_IE,
   output logic [3:0]      out_INM,
   output logic [3:0]      out_IG,
   output logic            out_redirect,
   output logic [PC_W-1:0] out_target,
   output logic [1:0]      out_depth,
   output logic            out_busy
);

   // state  | meaning
   // IDLE   | waiting for break, ERET or EI/DI
   // SAVE   | push return PC and mask, drop IE
   // ACK    | pulse IG for the serviced level
   // ENTER  | raise mask, redirect to level vector
   // RET    | redirect to popped return PC
   typedef enum logic [2:0] {S_IDLE, S_SAVE, S_ACK, S_ENTER, S_RET} state_t;

`ifdef INT_NEST_EN
   localparam logic [1:0] DEPTH_CAP = 2'(DEPTH);
   localparam logic       ENTER_IE  = 1'b1;
`else
   localparam logic [1:0] DEPTH_CAP = 2'd1;
   localparam logic       ENTER_IE  = 1'b0;
`endif

   state_t          state;
   logic [1:0]      lvl;
   logic [PC_W-1:0] pc_lat;
   logic [2:0]      inm;
   logic [2:0]      ig;
   logic [1:0]      depth;
   logic [PC_W-1:0] stk_pc   [DEPTH];
   logic [2:0]      stk_mask [DEPTH];

   logic            accept;
   logic            ret_ok;
   logic [2:0]      lvl_mask;
   logic [2:0]      lvl_onehot;
   logic [1:0]      top;

   always_comb begin
      ret_ok = in_ERET && (depth != 2'd0);
      accept = in_break && (in_code != 2'd0) && out_IE && (depth < DEPTH_CAP);
      top    = depth - 2'd1;
      lvl_mask   = 3'b000;
      lvl_onehot = 3'b000;
      case (lvl)
         2'd1:    begin lvl_mask = 3'b001; lvl_onehot = 3'b001; end
         2'd2:    begin lvl_mask = 3'b011; lvl_onehot = 3'b010; end
         2'd3:    begin lvl_mask = 3'b111; lvl_onehot = 3'b100; end
         default: begin lvl_mask = 3'b000; lvl_onehot = 3'b000; end
      endcase
   end

   always_ff @(posedge in_CLK) begin
      if (!in_RST) begin
         state        <= S_IDLE;
         lvl          <= 2'd0;
         pc_lat       <= '0;
         inm          <= 3'b000;
         ig           <= 3'b000;
         depth        <= 2'd0;
         out_IE       <= 1'b0;
         out_redirect <= 1'b0;
         out_target   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            stk_pc[i]   <= '0;
            stk_mask[i] <= 3'b000;
         end
      end else begin
         case (state)
            S_IDLE: begin
               // ERET has priority; a coincident break is re-evaluated after the return
               if (ret_ok) begin
                  out_target   <= stk_pc[top];
                  inm          <= stk_mask[top];
                  out_IE       <= 1'b1;
                  out_redirect <= 1'b1;
                  depth        <= top;
                  state        <= S_RET;
               end else if (accept) begin
                  lvl    <= in_code;
                  pc_lat <= in_PC;
                  state  <= S_SAVE;
               end else if (in_DI) begin
                  out_IE <= 1'b0;
               end else if (in_EI) begin
                  out_IE <= 1'b1;
               end
            end
            S_SAVE: begin
               stk_pc[depth]   <= pc_lat;
               stk_mask[depth] <= inm;
               depth           <= depth + 2'd1;
               out_IE          <= 1'b0;
               ig              <= lvl_onehot;
               state           <= S_ACK;
            end
            S_ACK: begin
               ig           <= 3'b000;
               inm          <= inm | lvl_mask;
               out_redirect <= 1'b1;
               out_target   <= VEC_BASE + PC_W'(lvl) * VEC_STRIDE;
               if (ENTER_IE)
                  out_IE <= 1'b1;
               state        <= S_ENTER;
            end
            S_ENTER: begin
               out_redirect <= 1'b0;
               state        <= S_IDLE;
            end
            S_RET: begin
               out_redirect <= 1'b0;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign out_INM   = {1'b0, inm};
   assign out_IG    = {1'b0, ig};
   assign out_depth = depth;
   assign out_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_int_service_seq.sv
// Bench for int_service_seq: directed test-plan steps then random traffic, all checked
// every cycle against a latency/stack reference model of the service sequence.
module tb_int_service_seq;

   localparam logic [31:0] VEC_BASE   = 32'h100;
   localparam logic [31:0] VEC_STRIDE = 32'h10;
`ifdef INT_NEST_EN
   localparam int  CAP  = 3;
   localparam bit  NEST = 1'b1;
`else
   localparam int  CAP  = 1;
   localparam bit  NEST = 1'b0;
`endif

   logic        in_CLK = 1'b0;
   logic        in_RST = 1'b0;
   logic [1:0]  in_code = 2'd0;
   logic        in_break = 1'b0;
   logic [31:0] in_PC = '0;
   logic        in_ERET = 1'b0;
   logic        in_EI = 1'b0;
   logic        in_DI = 1'b0;
   logic        out_IE;
   logic [3:0]  out_INM;
   logic [3:0]  out_IG;
   logic        out_redirect;
   logic [31:0] out_target;
   logic [1:0]  out_depth;
   logic        out_busy;

   int checks = 0;
   int errors = 0;

   int_service_seq dut (
      .in_CLK(in_CLK), .in_RST(in_RST), .in_code(in_code), .in_break(in_break),
      .in_PC(in_PC), .in_ERET(in_ERET), .in_EI(in_EI), .in_DI(in_DI),
      .out_IE(out_IE), .out_INM(out_INM), .out_IG(out_IG),
      .out_redirect(out_redirect), .out_target(out_target),
      .out_depth(out_depth), .out_busy(out_busy)
   );

   always #5 in_CLK = ~in_CLK;

   // Reference model: entry progresses 1 (latched) -> 2 (IG visible) -> 3 (redirect visible) -> 0
   int          ph = 0;
   bit          rt = 1'b0;
   logic [1:0]  m_lvl = 2'd0;
   logic [31:0] m_pc = '0;
   logic [31:0] m_target = '0;
   logic        m_ie = 1'b0;
   logic [2:0]  m_mask = 3'b000;
   logic [31:0] st_pc[$];
   logic [2:0]  st_mask[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [3:0] lm;
      if (!in_RST) begin
         ph = 0; rt = 1'b0; m_ie = 1'b0; m_mask = 3'b000; m_target = '0;
         st_pc.delete(); st_mask.delete();
      end else if (ph == 1) begin
         st_pc.push_back(m_pc); st_mask.push_back(m_mask);
         m_ie = 1'b0; ph = 2;
      end else if (ph == 2) begin
         lm = (4'd1 << m_lvl) - 4'd1;
         m_mask = m_mask | lm[2:0];
         m_target = VEC_BASE + 32'(m_lvl) * VEC_STRIDE;
         if (NEST) m_ie = 1'b1;
         ph = 3;
      end else if (ph == 3) begin
         ph = 0;
      end else if (rt) begin
         rt = 1'b0;
      end else if (in_ERET && st_pc.size() > 0) begin
         m_target = st_pc.pop_back(); m_mask = st_mask.pop_back();
         m_ie = 1'b1; rt = 1'b1;
      end else if (in_break && in_code != 2'd0 && m_ie && st_pc.size() < CAP) begin
         m_lvl = in_code; m_pc = in_PC; ph = 1;
      end else if (in_DI) begin
         m_ie = 1'b0;
      end else if (in_EI) begin
         m_ie = 1'b1;
      end
   endtask

   task automatic check_all();
      logic [3:0] exp_ig;
      exp_ig = (ph == 2) ? (4'd1 << (m_lvl - 2'd1)) : 4'd0;
      chk("ie", 32'(out_IE), 32'(m_ie));
      chk("inm", 32'(out_INM), {29'd0, m_mask});
      chk("ig", 32'(out_IG), 32'(exp_ig));
      chk("redirect", 32'(out_redirect), 32'(ph == 3 || rt));
      chk("target", out_target, m_target);
      chk("depth", 32'(out_depth), 32'(st_pc.size()));
      chk("busy", 32'(out_busy), 32'(ph != 0 || rt));
   endtask

   task automatic step(input logic rst, input logic [1:0] code, input logic brk,
                       input logic [31:0] pc, input logic eret, input logic ei, input logic di);
      in_RST = rst; in_code = code; in_break = brk; in_PC = pc;
      in_ERET = eret; in_EI = ei; in_DI = di;
      @(posedge in_CLK);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // reset
      step(1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("reset_target", out_target, 32'h0);
      chk("reset_depth", 32'(out_depth), 32'h0);

      // basic entry: level 2 at PC 0x40
      step(1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 2'd2, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("basic_ig", 32'(out_IG), 32'h2);
      step(1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("basic_ig_drop", 32'(out_IG), 32'h0);
      chk("basic_redirect", 32'(out_redirect), 32'h1);
      chk("basic_target", out_target, 32'h120);
      chk("basic_inm", 32'(out_INM), 32'h3);
      chk("basic_depth", 32'(out_depth), 32'h1);
      chk("basic_ie", 32'(out_IE), 32'(NEST));
      idle(2);

      // return
      step(1'b1, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("ret_redirect", 32'(out_redirect), 32'h1);
      chk("ret_target", out_target, 32'h40);
      chk("ret_inm", 32'(out_INM), 32'h0);
      chk("ret_ie", 32'(out_IE), 32'h1);
      chk("ret_depth", 32'(out_depth), 32'h0);
      idle(2);

      // ERET at depth 0 is ignored
      step(1'b1, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("eret0_redirect", 32'(out_redirect), 32'h0);
      chk("eret0_busy", 32'(out_busy), 32'h0);

      // level 1 entry at PC 0x40
      step(1'b1, 2'd1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      idle(4);
      if (NEST) begin
         step(1'b1, 2'd3, 1'b1, 32'h114, 1'b0, 1'b0, 1'b0);
         idle(2);
         chk("nest_target", out_target, 32'h130);
         chk("nest_inm", 32'(out_INM), 32'h7);
         chk("nest_depth", 32'(out_depth), 32'h2);
         idle(2);
         step(1'b1, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
         chk("nest_ret1", out_target, 32'h114);
         chk("nest_ret1_inm", 32'(out_INM), 32'h1);
         idle(2);
         step(1'b1, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
         chk("nest_ret2", out_target, 32'h40);
         chk("nest_ret2_inm", 32'(out_INM), 32'h0);
         idle(2);
      end else begin
         // stack full: IE re-enabled by software, held break must not be accepted
         step(1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
         for (int i = 0; i < 5; i++) step(1'b1, 2'd2, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
         chk("full_busy", 32'(out_busy), 32'h0);
         chk("full_depth", 32'(out_depth), 32'h1);
         chk("full_ig", 32'(out_IG), 32'h0);
         // ERET and break together: return first, entry accepted after it
         step(1'b1, 2'd2, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
         chk("coll_ret_target", out_target, 32'h40);
         step(1'b1, 2'd2, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
         chk("coll_idle", 32'(out_busy), 32'h0);
         step(1'b1, 2'd2, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
         chk("coll_accept", 32'(out_busy), 32'h1);
         idle(4);
         step(1'b1, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
         idle(2);
      end

      // EI and DI together: DI wins
      step(1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("eidi_ie", 32'(out_IE), 32'h0);

      // reset during ACK
      step(1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 2'd3, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'd3, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_ig", 32'(out_IG), 32'h4);
      step(1'b0, 2'd3, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
      chk("rst_ack_ig", 32'(out_IG), 32'h0);
      chk("rst_ack_depth", 32'(out_depth), 32'h0);
      chk("rst_ack_redirect", 32'(out_redirect), 32'h0);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         logic r_rst;
         r_rst = ($urandom_range(0, 199) != 0);
         step(r_rst, 2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0),
              $urandom(), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
